cache_mem_arbiter: RTL

Arbitrates the icache and dcache miss/writeback traffic onto the single-ported RAM. Sits directly downstream of the dcache (and the icache), consuming their `caches_if` request signals and returning `dwait`/`dload` and `iwait`/`iload`. It keeps the two-word dcache block transfers (writeback word 0/1, fill word 0/1) atomic and alternates grants fairly when both caches contend.

---
 rtl/cache_mem_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache and dcache traffic onto the single-ported RAM. Keeps the
// two-word dcache block transfers atomic and alternates grants under contention.
//
// state  | meaning
// IDLE   | no grant; dead cycle between transfers, grant selection happens here
// DREAD  | dcache read granted, ramREN driven until ACCESS or request drops
// DWRITE | dcache write granted, ramWEN driven until ACCESS or request drops
// IREAD  | icache read granted, ramREN driven until ACCESS or request drops
module cache_mem_arbiter #(
   parameter int WORD_W = 32
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [WORD_W-1:0] iaddr,
   output logic              iwait,
   output logic [WORD_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [WORD_W-1:0] daddr,
   input  logic [WORD_W-1:0] dstore,
   output logic              dwait,
   output logic [WORD_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [WORD_W-1:0] ramaddr,
   output logic [WORD_W-1:0] ramstore,
   input  logic [WORD_W-1:0] ramload,
   input  logic [1:0]        ramstate
);

   localparam logic [1:0] RAM_ACCESS = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DREAD  = 2'd1,
      ST_DWRITE = 2'd2,
      ST_IREAD  = 2'd3
   } state_e;

   state_e state_q, state_d;
   logic   last_d_q, last_d_d;
   logic   dlock_q, dlock_d;

   logic   d_req;
   logic   d_held;
   logic   ram_done;
   state_e d_state;

   assign d_req    = dREN | dWEN;
   assign d_state  = dWEN ? ST_DWRITE : ST_DREAD;
   assign d_held   = (state_q == ST_DWRITE) ? dWEN : dREN;
   assign ram_done = (ramstate == RAM_ACCESS);

   assign iload = ramload;
   assign dload = ramload;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= ST_IDLE;
         last_d_q <= 1'b0;
         dlock_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_d_q <= last_d_d;
         dlock_q  <= dlock_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      last_d_d = last_d_q;
      dlock_d  = dlock_q;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = 1'b1;
      dwait    = 1'b1;

      case (state_q)
         ST_IDLE: begin
            // An abandoned half block must not lock out the icache.
            if (!d_req) dlock_d = 1'b0;

            if (dlock_q && d_req)    state_d = d_state;
            else if (d_req && iREN)  state_d = last_d_q ? ST_IREAD : d_state;
            else if (d_req)          state_d = d_state;
            else if (iREN)           state_d = ST_IREAD;
         end

         ST_DREAD, ST_DWRITE: begin
            if (!d_held) begin
               state_d = ST_IDLE;
            end else begin
               ramREN  = (state_q == ST_DREAD);
               ramWEN  = (state_q == ST_DWRITE);
               ramaddr = daddr;
               if (state_q == ST_DWRITE) ramstore = dstore;
               if (ram_done) begin
                  dwait    = 1'b0;
                  state_d  = ST_IDLE;
                  last_d_d = 1'b1;
                  dlock_d  = ~daddr[2];
               end
            end
         end

         ST_IREAD: begin
            if (!iREN) begin
               state_d = ST_IDLE;
            end else begin
               ramREN  = 1'b1;
               ramaddr = iaddr;
               if (ram_done) begin
                  iwait    = 1'b0;
                  state_d  = ST_IDLE;
                  last_d_d = 1'b0;
                  dlock_d  = 1'b0;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

endmodule
